// File: rtl/pio_instr_fetch.sv
// Instruction fetch/decode front end for a PIO state machine: 32-word program
// memory, single-entry immediate-instruction slot, JMP condition evaluation.
module pio_instr_fetch #(
    parameter int unsigned EXEC_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  penable,
    input  logic                  stalled,
    input  logic [4:0]            pc_addr,
    input  logic                  imem_wr,
    input  logic [4:0]            imem_waddr,
    input  logic [15:0]           imem_wdata,
    input  logic                  imm_valid,
    input  logic [15:0]           imm_instr,
    output logic                  imm_ready,
    input  logic [31:0]           x,
    input  logic [31:0]           y,
    input  logic                  jmp_pin,
    input  logic                  osre,
    output logic [15:0]           instr,
    output logic                  imm,
    output logic                  exec,
    output logic                  jmp,
    output logic [4:0]            jmp_target,
    output logic                  x_dec,
    output logic                  y_dec,
    output logic [EXEC_CNT_W-1:0] exec_count
);

    logic [15:0] mem [32];
    logic [15:0] mem_rd;
    logic        imm_active;
    logic [15:0] imm_reg;
    logic        is_jmp;
    logic [2:0]  cond;
    logic        cond_true;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) mem[i] <= '0;
        end else if (imem_wr) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    // Write-first bypass so the PC sees a word being loaded in the same cycle.
    always_comb begin
        if (!reset && imem_wr && (imem_waddr == pc_addr)) mem_rd = imem_wdata;
        else                                             mem_rd = mem[pc_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imm_active <= 1'b0;
            imm_reg    <= '0;
        end else if (imm_active) begin
            if (!stalled) imm_active <= 1'b0;
        end else if (imm_valid) begin
            imm_active <= 1'b1;
            imm_reg    <= imm_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     exec_count <= '0;
        else if (exec) exec_count <= exec_count + 1'b1;
    end

    assign imm_ready  = !imm_active;
    assign imm        = imm_active;
    assign instr      = imm_active ? imm_reg : mem_rd;
    assign exec       = (penable || imm_active) && !stalled;
    assign is_jmp     = (instr[15:13] == 3'b000);
    assign cond       = instr[7:5];
    assign jmp_target = instr[4:0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'd0: cond_true = 1'b1;
            3'd1: cond_true = (x == 32'd0);
            3'd2: cond_true = (x != 32'd0);
            3'd3: cond_true = (y == 32'd0);
            3'd4: cond_true = (y != 32'd0);
            3'd5: cond_true = (x != y);
            3'd6: cond_true = jmp_pin;
            3'd7: cond_true = !osre;
            default: cond_true = 1'b0;
        endcase
    end

    assign jmp   = exec && is_jmp && cond_true;
    assign x_dec = exec && is_jmp && (cond == 3'd2);
    assign y_dec = exec && is_jmp && (cond == 3'd4);

endmodule

// File: tb/tb_pio_instr_fetch.sv
// Directed self-checking bench for pio_instr_fetch.
module tb_pio_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        penable;
    logic        stalled;
    logic [4:0]  pc_addr;
    logic        imem_wr;
    logic [4:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        imm_valid;
    logic [15:0] imm_instr;
    logic        imm_ready;
    logic [31:0] x;
    logic [31:0] y;
    logic        jmp_pin;
    logic        osre;
    logic [15:0] instr;
    logic        imm;
    logic        exec;
    logic        jmp;
    logic [4:0]  jmp_target;
    logic        x_dec;
    logic        y_dec;
    logic [15:0] exec_count;

    int n_checks = 0;
    int n_pass   = 0;

    pio_instr_fetch #(.EXEC_CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .penable    (penable),
        .stalled    (stalled),
        .pc_addr    (pc_addr),
        .imem_wr    (imem_wr),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .imm_valid  (imm_valid),
        .imm_instr  (imm_instr),
        .imm_ready  (imm_ready),
        .x          (x),
        .y          (y),
        .jmp_pin    (jmp_pin),
        .osre       (osre),
        .instr      (instr),
        .imm        (imm),
        .exec       (exec),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .x_dec      (x_dec),
        .y_dec      (y_dec),
        .exec_count (exec_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    initial begin
        reset = 1'b1; penable = 1'b0; stalled = 1'b0; pc_addr = 5'd0;
        imem_wr = 1'b0; imem_waddr = 5'd0; imem_wdata = 16'h0000;
        imm_valid = 1'b0; imm_instr = 16'h0000;
        x = 32'd0; y = 32'd0; jmp_pin = 1'b0; osre = 1'b0;

        // reset state
        step(); step();
        chk("rst_instr", 32'(instr), 32'h0000);
        chk("rst_imm", 32'(imm), 32'd0);
        chk("rst_cnt", 32'(exec_count), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_instr", 32'(instr), 32'h0000);
        chk("rel_ready", 32'(imm_ready), 32'd1);
        chk("rel_jmptgt", 32'(jmp_target), 32'd0);

        // program load
        imem_wr = 1'b1; imem_waddr = 5'd3; imem_wdata = 16'h0025;
        step();
        imem_waddr = 5'd4; imem_wdata = 16'h0049;
        step();
        imem_wr = 1'b0;
        chk("load_cnt", 32'(exec_count), 32'd0);

        // JMP !X,5
        pc_addr = 5'd3; penable = 1'b1; x = 32'd0;
        #1;
        chk("nx_exec", 32'(exec), 32'd1);
        chk("nx_jmp_x0", 32'(jmp), 32'd1);
        chk("nx_tgt", 32'(jmp_target), 32'd5);
        chk("nx_xdec", 32'(x_dec), 32'd0);
        x = 32'd7;
        #1;
        chk("nx_jmp_x7", 32'(jmp), 32'd0);
        chk("nx_tgt_x7", 32'(jmp_target), 32'd5);

        // JMP X--,9
        pc_addr = 5'd4; x = 32'd0;
        #1;
        chk("xd_jmp_x0", 32'(jmp), 32'd0);
        chk("xd_xdec_x0", 32'(x_dec), 32'd1);
        chk("xd_ydec", 32'(y_dec), 32'd0);
        x = 32'd1;
        #1;
        chk("xd_jmp_x1", 32'(jmp), 32'd1);
        chk("xd_xdec_x1", 32'(x_dec), 32'd1);
        chk("xd_tgt", 32'(jmp_target), 32'd9);
        stalled = 1'b1;
        #1;
        chk("xd_stl_jmp", 32'(jmp), 32'd0);
        chk("xd_stl_xdec", 32'(x_dec), 32'd0);
        chk("xd_stl_exec", 32'(exec), 32'd0);
        step();
        chk("xd_stl_cnt", 32'(exec_count), 32'd0);
        stalled = 1'b0;
        step();
        chk("xd_run_cnt", 32'(exec_count), 32'd1);
        penable = 1'b0;

        // immediate with penable=0
        imm_valid = 1'b1; imm_instr = 16'h000C;
        #1;
        chk("im_ready_pre", 32'(imm_ready), 32'd1);
        step();
        imm_valid = 1'b0;
        chk("im_imm", 32'(imm), 32'd1);
        chk("im_ready", 32'(imm_ready), 32'd0);
        chk("im_instr", 32'(instr), 32'h000C);
        chk("im_jmp", 32'(jmp), 32'd1);
        chk("im_tgt", 32'(jmp_target), 32'd12);
        step();
        chk("im_done_imm", 32'(imm), 32'd0);
        chk("im_done_ready", 32'(imm_ready), 32'd1);
        chk("im_done_cnt", 32'(exec_count), 32'd2);

        // stalled immediate, second request ignored
        stalled = 1'b1; imm_valid = 1'b1; imm_instr = 16'h0011;
        step();
        imm_instr = 16'h0002;
        for (int i = 0; i < 3; i++) begin
            chk("st_imm", 32'(imm), 32'd1);
            chk("st_exec", 32'(exec), 32'd0);
            chk("st_instr", 32'(instr), 32'h0011);
            chk("st_cnt", 32'(exec_count), 32'd2);
            step();
        end
        imm_valid = 1'b0; stalled = 1'b0;
        #1;
        chk("st_rel_exec", 32'(exec), 32'd1);
        chk("st_rel_jmp", 32'(jmp), 32'd1);
        chk("st_rel_tgt", 32'(jmp_target), 32'd17);
        step();
        chk("st_cnt_inc", 32'(exec_count), 32'd3);
        chk("st_imm_clr", 32'(imm), 32'd0);
        chk("st_back_mem", 32'(instr), 32'h0049);
        chk("st_no_exec", 32'(exec), 32'd0);
        step();
        chk("st_no_requeue", 32'(imm), 32'd0);
        chk("st_cnt_hold", 32'(exec_count), 32'd3);

        // write-first bypass
        pc_addr = 5'd7; penable = 1'b1;
        imem_wr = 1'b1; imem_waddr = 5'd7; imem_wdata = 16'hE001;
        #1;
        chk("byp_instr", 32'(instr), 32'hE001);
        chk("byp_jmp", 32'(jmp), 32'd0);
        step();
        imem_wr = 1'b0;
        #1;
        chk("byp_stored", 32'(instr), 32'hE001);
        chk("byp_cnt", 32'(exec_count), 32'd4);
        step();
        chk("cnt5", 32'(exec_count), 32'd5);
        penable = 1'b0;

        // reset mid-immediate
        stalled = 1'b1; imm_valid = 1'b1; imm_instr = 16'h0005;
        step();
        imm_valid = 1'b0;
        chk("pre_rst_imm", 32'(imm), 32'd1);
        chk("pre_rst_cnt", 32'(exec_count), 32'd5);
        reset = 1'b1; imm_valid = 1'b1; imm_instr = 16'h1234;
        imem_wr = 1'b1; imem_waddr = 5'd0; imem_wdata = 16'hFFFF;
        step();
        reset = 1'b0; imm_valid = 1'b0; imem_wr = 1'b0; stalled = 1'b0;
        #1;
        chk("mr_imm", 32'(imm), 32'd0);
        chk("mr_ready", 32'(imm_ready), 32'd1);
        chk("mr_cnt", 32'(exec_count), 32'd0);
        for (int a = 0; a < 32; a++) begin
            pc_addr = 5'(a);
            #1;
            chk("mr_mem", 32'(instr), 32'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pio_instr_fetch.md
PIO_INSTR_FETCH -- requirements
Module: pio_instr_fetch

Interface
REQ-001 SHALL have parameter: EXEC_CNT_W, 16, width of executed-instruction counter.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: penable  input  1  state machine enabled; stalled  input  1  current instruction stalled.
REQ-005 SHALL have port: pc_addr  input  5  address from the program counter.
REQ-006 SHALL have ports: imem_wr  input  1; imem_waddr  input  5; imem_wdata  input  16  host program-load write port.
REQ-007 SHALL have ports: imm_valid  input  1; imm_instr  input  16; imm_ready  output  1  immediate-instruction handshake.
REQ-008 SHALL have ports: x, y  input  32 each  scratch registers; jmp_pin  input  1; osre  input  1  OSR-empty flag.
REQ-009 SHALL have ports: instr  output  16  current instruction; imm  output  1  immediate active; exec  output  1  instruction executes this cycle.
REQ-010 SHALL have ports: jmp  output  1  jump taken; jmp_target  output  5; x_dec, y_dec  output  1 each  post-decrement requests.
REQ-011 SHALL have port: exec_count  output  EXEC_CNT_W  executed-instruction count.

Function
REQ-012 SHALL hold a 32 x 16-bit instruction memory; imem_wr=1 writes imem_wdata to imem_waddr at the clock edge.
REQ-013 SHALL read memory combinationally at pc_addr; write to pc_addr in the same cycle SHALL bypass, so instr shows imem_wdata that cycle (write-first).
REQ-014 SHALL hold imm_active flag and 16-bit imm_reg; imm_ready = !imm_active.
REQ-015 SHALL capture imm_instr into imm_reg and set imm_active on an edge where imm_valid && imm_ready; imm_valid while imm_active SHALL be ignored (not captured, not queued).
REQ-016 SHALL drive instr = imm_reg when imm_active, else memory data (REQ-013); imm = imm_active.
REQ-017 SHALL drive exec = (penable || imm_active) && !stalled; immediates execute even when penable=0.
REQ-018 SHALL clear imm_active on the edge where exec=1 with imm_active=1; a stalled immediate SHALL stay active, instr unchanged.
REQ-019 SHALL accept a new immediate no earlier than the cycle after imm_active clears (one immediate in flight, minimum 2 cycles per immediate).
REQ-020 SHALL decode JMP as instr[15:13]=3'b000, condition instr[7:5], target instr[4:0]; jmp_target = instr[4:0] always.
REQ-021 SHALL evaluate conditions: 0 always; 1 x==0; 2 x!=0; 3 y==0; 4 y!=0; 5 x!=y; 6 jmp_pin==1; 7 osre==0.
REQ-022 SHALL drive jmp = exec && is_jmp && condition true; jmp=0 whenever exec=0.
REQ-023 SHALL drive x_dec = exec && is_jmp && cond==2, y_dec = exec && is_jmp && cond==4, whether or not taken (x/y decremented after test, including from 0).
REQ-024 SHALL increment exec_count by 1 each edge with exec=1, wrapping modulo 2^EXEC_CNT_W.
REQ-025 SHALL treat all outputs except exec_count and imm_ready as combinational from current state and inputs (zero-cycle latency to the program counter).

Reset
REQ-026 SHALL on reset clear imm_active, imm_reg, exec_count and all 32 memory words to 16'h0000; reset overrides same-cycle imem_wr and imm_valid.
REQ-027 SHALL drop an in-flight immediate on reset mid-operation; imm_ready=1 the cycle after reset deasserts.
REQ-028 SHALL, while reset asserted and after release with pc_addr=0, present instr=16'h0000 (JMP always to 0), imm=0, exec_count=0.

Verification
REQ-029 SHALL test: write 16'h0025 at addr 3 (JMP !X,5), x=0, pc_addr=3, penable=1 -> jmp=1, jmp_target=5; x=7 -> jmp=0.
REQ-030 SHALL test: addr 4 = 16'h0049 (JMP X--,9), x=0 -> jmp=0, x_dec=1; x=1 -> jmp=1, x_dec=1; stalled=1 -> jmp=0, x_dec=0.
REQ-031 SHALL test: penable=0, imm_valid=1, imm_instr=16'h000C -> next cycle imm=1, imm_ready=0, jmp=1, jmp_target=12; following cycle imm=0, imm_ready=1.
REQ-032 SHALL test: immediate held with stalled=1 three cycles -> imm=1, exec=0, exec_count unchanged, second imm_valid ignored; stalled=0 -> one execution, count +1.
REQ-033 SHALL test: imem_wr to addr=pc_addr=7 with 16'hE001 -> instr=16'hE001 same cycle, jmp=0.
REQ-034 SHALL test: reset asserted while imm_active=1 and exec_count=5 -> next cycle imm=0, exec_count=0, all memory reads 16'h0000.
